// File: rtl/vec_mem_sequencer_pkg.sv
// Shared definitions for the vector/scalar Avalon-MM data-port sequencer.
// Holds the FSM state encoding, the beat geometry (how many 32-bit Avalon
// beats make up one vector access) and the beat-index width.
package vec_mem_sequencer_pkg;

    localparam int VMS_ADDR_W     = 32;
    localparam int VMS_BEAT_W     = 32;
    localparam int VMS_VEC_W      = 128;
    localparam int VMS_BEATS      = VMS_VEC_W / VMS_BEAT_W;
    localparam int VMS_BEAT_IDX_W = $clog2(VMS_BEATS);

    typedef logic [VMS_BEAT_IDX_W-1:0] vms_beat_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } vms_state_t;

endpackage

// File: rtl/vec_mem_sequencer.sv
// Avalon-MM data-port sequencer for the core's memory stage.
// Splits a scalar (1 beat) or vector (4 beats) load/store into single-word
// Avalon transfers, assembles 128-bit load data and stalls the pipeline until
// the access completes.
//
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   mem_read, mem_write           requests from memory stage (write wins)
//   vector_op                     1 = 128-bit access, 0 = 32-bit access
//   addr, wdata                   base byte address and store data
//   rdata, rdata_valid            assembled load data, 1-cycle completion pulse
//   stall, busy                   hazard-unit stall (combinational), FSM active
//   avm_*                         Avalon-MM master (all outputs registered)
module vec_mem_sequencer
    import vec_mem_sequencer_pkg::*;
#(
    parameter int ADDR_W = VMS_ADDR_W,
    parameter int BEAT_W = VMS_BEAT_W,
    parameter int VEC_W  = VMS_VEC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              vector_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [VEC_W-1:0]  wdata,
    output logic [VEC_W-1:0]  rdata,
    output logic              rdata_valid,
    output logic              stall,
    output logic              busy,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [BEAT_W-1:0] avm_writedata,
    input  logic [BEAT_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
);

    vms_state_t        state_r,  state_s;
    vms_beat_t         beat_r,   beat_s;
    logic [ADDR_W-1:0] base_r,   base_s;
    logic [VEC_W-1:0]  wbuf_r,   wbuf_s;
    logic              vec_r,    vec_s;
    logic              load_r,   load_s;
    logic [VEC_W-1:0]  rdata_r,  rdata_s;
    logic              last_beat_s;

    logic [ADDR_W-1:0] avm_address_r, avm_address_s;
    logic [BEAT_W-1:0] avm_writedata_r, avm_writedata_s;
    logic              avm_read_r, avm_write_r, rdata_valid_r, busy_r;

    // Last beat of the current access: beat 0 for scalar, beat 3 for vector.
    always_comb begin
        if (vec_r) begin
            last_beat_s = (beat_r == VMS_BEAT_IDX_W'(VMS_BEATS - 1));
        end else begin
            last_beat_s = (beat_r == {VMS_BEAT_IDX_W{1'b0}});
        end
    end

    // Next-state, beat counter and latched-request logic.
    always_comb begin
        state_s = state_r;
        beat_s  = beat_r;
        base_s  = base_r;
        wbuf_s  = wbuf_r;
        vec_s   = vec_r;
        load_s  = load_r;
        rdata_s = rdata_r;
        case (state_r)
            IDLE: begin
                if (mem_write) begin
                    // Store takes priority when both requests are raised.
                    base_s  = addr & {{(ADDR_W-2){1'b1}}, 2'b00};
                    wbuf_s  = wdata;
                    vec_s   = vector_op;
                    load_s  = 1'b0;
                    beat_s  = {VMS_BEAT_IDX_W{1'b0}};
                    state_s = WR_REQ;
                end else if (mem_read) begin
                    base_s  = addr & {{(ADDR_W-2){1'b1}}, 2'b00};
                    wbuf_s  = wdata;
                    vec_s   = vector_op;
                    load_s  = 1'b1;
                    beat_s  = {VMS_BEAT_IDX_W{1'b0}};
                    rdata_s = {VEC_W{1'b0}};
                    state_s = RD_REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    state_s = RD_WAIT;
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    rdata_s[BEAT_W*beat_r +: BEAT_W] = avm_readdata;
                    if (last_beat_s) begin
                        state_s = DONE;
                    end else begin
                        beat_s  = beat_r + VMS_BEAT_IDX_W'(1);
                        state_s = RD_REQ;
                    end
                end else begin
                    state_s = RD_WAIT;
                end
            end
            WR_REQ: begin
                if (!avm_waitrequest) begin
                    if (last_beat_s) begin
                        state_s = DONE;
                    end else begin
                        beat_s  = beat_r + VMS_BEAT_IDX_W'(1);
                        state_s = WR_REQ;
                    end
                end else begin
                    state_s = WR_REQ;
                end
            end
            DONE: begin
                // Request still visible here belongs to the finished access.
                beat_s  = {VMS_BEAT_IDX_W{1'b0}};
                state_s = IDLE;
            end
            default: begin
                beat_s  = {VMS_BEAT_IDX_W{1'b0}};
                state_s = IDLE;
            end
        endcase
    end

    // Avalon address/data for the beat the FSM will be presenting next cycle.
    always_comb begin
        avm_address_s   = base_s + ADDR_W'({beat_s, 2'b00});
        avm_writedata_s = wbuf_s[BEAT_W*beat_s +: BEAT_W];
    end

    // State, datapath and registered-output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            beat_r          <= {VMS_BEAT_IDX_W{1'b0}};
            base_r          <= {ADDR_W{1'b0}};
            wbuf_r          <= {VEC_W{1'b0}};
            vec_r           <= 1'b0;
            load_r          <= 1'b0;
            rdata_r         <= {VEC_W{1'b0}};
            avm_address_r   <= {ADDR_W{1'b0}};
            avm_writedata_r <= {BEAT_W{1'b0}};
            avm_read_r      <= 1'b0;
            avm_write_r     <= 1'b0;
            rdata_valid_r   <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r       <= state_s;
            beat_r        <= beat_s;
            base_r        <= base_s;
            wbuf_r        <= wbuf_s;
            vec_r         <= vec_s;
            load_r        <= load_s;
            rdata_r       <= rdata_s;
            avm_read_r    <= (state_s == RD_REQ);
            avm_write_r   <= (state_s == WR_REQ);
            rdata_valid_r <= (state_s == DONE) && load_s;
            busy_r        <= (state_s != IDLE);
            if ((state_s == RD_REQ) || (state_s == WR_REQ)) begin
                avm_address_r   <= avm_address_s;
                avm_writedata_r <= avm_writedata_s;
            end else begin
                avm_address_r   <= avm_address_r;
                avm_writedata_r <= avm_writedata_r;
            end
        end
    end

    // Stall is the only combinational output: it must cover the IDLE accept
    // cycle and release in DONE so the pipeline advances exactly once.
    assign stall = ((state_r == IDLE) && (mem_read || mem_write)) ||
                   ((state_r != IDLE) && (state_r != DONE));

    assign rdata         = rdata_r;
    assign rdata_valid   = rdata_valid_r;
    assign busy          = busy_r;
    assign avm_address   = avm_address_r;
    assign avm_read      = avm_read_r;
    assign avm_write     = avm_write_r;
    assign avm_writedata = avm_writedata_r;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed testbench for vec_mem_sequencer: a reactive Avalon slave inside
// run_access records each accepted beat and the stall length of an access.
module tb_vec_mem_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write, vector_op;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         rdata_valid, stall, busy;
    logic [31:0]  avm_address;
    logic         avm_read, avm_write;
    logic [31:0]  avm_writedata, avm_readdata;
    logic         avm_waitrequest, avm_readdatavalid;

    int           n_tests = 0;
    int           n_fail  = 0;

    logic [31:0]  acc_addr [4];
    logic [31:0]  acc_data [4];
    int           n_acc, n_rd, n_wr, stall_cnt;
    logic         done_seen, done_rv, done_avm, done_busy, aborted;

    vec_mem_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .vector_op         (vector_op),
        .addr              (addr),
        .wdata             (wdata),
        .rdata             (rdata),
        .rdata_valid       (rdata_valid),
        .stall             (stall),
        .busy              (busy),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and play the Avalon slave until DONE (or an abort).
    // Called at posedge+1; returns at posedge+1 of the cycle after DONE.
    task automatic run_access(input logic rd, input logic wr, input logic vec,
                              input logic [31:0] a, input logic [127:0] wd,
                              input logic [127:0] rd_vec, input int wait_beat,
                              input int wait_cycles, input int abort_beat,
                              input logic hold_done);
        int          waited;
        logic        pend, prev_wait;
        logic [31:0] pend_data, prev_addr, prev_wd;
        n_acc = 0; n_rd = 0; n_wr = 0; stall_cnt = 0;
        done_seen = 1'b0; aborted = 1'b0; done_rv = 1'b0; done_avm = 1'b0; done_busy = 1'b0;
        waited = 0; pend = 1'b0; prev_wait = 1'b0;
        pend_data = 32'h0; prev_addr = 32'h0; prev_wd = 32'h0;
        mem_read = rd; mem_write = wr; vector_op = vec; addr = a; wdata = wd;
        for (int cyc = 0; cyc < 80 && !done_seen && !aborted; cyc++) begin
            #1;
            avm_readdatavalid = pend;
            avm_readdata      = pend ? pend_data : 32'h0;
            avm_waitrequest   = 1'b0;
            if (pend && (abort_beat == n_acc - 1)) begin
                rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
                avm_readdatavalid = 1'b0; aborted = 1'b1;
            end else begin
                pend = 1'b0;
                if (stall) begin
                    stall_cnt++;
                end else if (cyc > 0) begin
                    done_seen = 1'b1; done_rv = rdata_valid;
                    done_avm = avm_read | avm_write; done_busy = busy;
                    if (!hold_done) begin
                        mem_read = 1'b0; mem_write = 1'b0;
                    end
                end
                if (avm_read || avm_write) begin
                    if (prev_wait) begin
                        check_val("wait_addr_stable", {96'h0, avm_address}, {96'h0, prev_addr});
                        if (avm_write) check_val("wait_wdata_stable", {96'h0, avm_writedata}, {96'h0, prev_wd});
                    end
                    if ((n_acc == wait_beat) && (waited < wait_cycles)) begin
                        avm_waitrequest = 1'b1; waited++; prev_wait = 1'b1;
                        prev_addr = avm_address; prev_wd = avm_writedata;
                    end else begin
                        prev_wait = 1'b0;
                        if (n_acc < 4) begin
                            acc_addr[n_acc] = avm_address;
                            acc_data[n_acc] = avm_writedata;
                            pend_data = rd_vec[32*n_acc +: 32];
                        end
                        if (avm_read) begin
                            n_rd++; pend = 1'b1;
                        end else begin
                            n_wr++;
                        end
                        n_acc++;
                    end
                end else begin
                    prev_wait = 1'b0;
                end
            end
            @(posedge clk);
        end
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        check_val("access_terminated", {127'h0, done_seen | aborted}, 128'h1);
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; vector_op = 1'b0;
        addr = 32'h0; wdata = 128'h0; avm_readdata = 32'h0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_busy",  {127'h0, busy}, 128'h0);
        check_val("rst_stall", {127'h0, stall}, 128'h0);
        check_val("rst_rw",    {126'h0, avm_read, avm_write}, 128'h0);
        check_val("rst_rv",    {127'h0, rdata_valid}, 128'h0);
        check_val("rst_rdata", rdata, 128'h0);
        check_val("rst_addr",  {96'h0, avm_address}, 128'h0);
        check_val("rst_wd",    {96'h0, avm_writedata}, 128'h0);

        // Vector load, unaligned base 0x203 -> word-aligned 0x200.
        run_access(1'b1, 1'b0, 1'b1, 32'h0000_0203, 128'h0,
                   128'h44444444_33333333_22222222_11111111, -1, 0, -1, 1'b0);
        check_val("vld_stall", stall_cnt, 9);
        check_val("vld_nrd",   n_rd, 4);
        check_val("vld_a0", {96'h0, acc_addr[0]}, 128'h200);
        check_val("vld_a1", {96'h0, acc_addr[1]}, 128'h204);
        check_val("vld_a2", {96'h0, acc_addr[2]}, 128'h208);
        check_val("vld_a3", {96'h0, acc_addr[3]}, 128'h20C);
        check_val("vld_rdata", rdata, 128'h44444444_33333333_22222222_11111111);
        check_val("vld_done_rv",   {127'h0, done_rv}, 128'h1);
        check_val("vld_done_busy", {127'h0, done_busy}, 128'h1);
        check_val("vld_rv_pulse",  {127'h0, rdata_valid}, 128'h0);

        // Scalar load: upper 96 bits of the previous vector data must clear.
        run_access(1'b1, 1'b0, 1'b0, 32'h0000_0100, 128'h0,
                   128'h0_DEADBEEF, -1, 0, -1, 1'b0);
        check_val("sld_stall", stall_cnt, 3);
        check_val("sld_nrd",   n_rd, 1);
        check_val("sld_a0",    {96'h0, acc_addr[0]}, 128'h100);
        check_val("sld_rdata", rdata, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
        check_val("sld_done_rv",  {127'h0, done_rv}, 128'h1);
        check_val("sld_done_avm", {127'h0, done_avm}, 128'h0);

        // Vector store with 2 waitrequest cycles on beat 1.
        run_access(1'b0, 1'b1, 1'b1, 32'h0000_0080,
                   128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 128'h0, 1, 2, -1, 1'b0);
        check_val("vst_stall", stall_cnt, 7);
        check_val("vst_nwr",   n_wr, 4);
        check_val("vst_nrd",   n_rd, 0);
        check_val("vst_d0", {96'h0, acc_data[0]}, 128'hA0A0A0A0);
        check_val("vst_d1", {96'h0, acc_data[1]}, 128'hA1A1A1A1);
        check_val("vst_d2", {96'h0, acc_data[2]}, 128'hA2A2A2A2);
        check_val("vst_d3", {96'h0, acc_data[3]}, 128'hA3A3A3A3);
        check_val("vst_a1", {96'h0, acc_addr[1]}, 128'h84);
        check_val("vst_a3", {96'h0, acc_addr[3]}, 128'h8C);
        check_val("vst_done_rv",  {127'h0, done_rv}, 128'h0);
        check_val("vst_done_avm", {127'h0, done_avm}, 128'h0);
        check_val("vst_rdata_hold", rdata, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);

        // Address wrap across 2^32.
        run_access(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 128'h0,
                   128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, -1, 0, -1, 1'b0);
        check_val("wrap_a0", {96'h0, acc_addr[0]}, 128'hFFFF_FFF8);
        check_val("wrap_a1", {96'h0, acc_addr[1]}, 128'hFFFF_FFFC);
        check_val("wrap_a2", {96'h0, acc_addr[2]}, 128'h0);
        check_val("wrap_a3", {96'h0, acc_addr[3]}, 128'h4);
        check_val("wrap_rdata", rdata, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);

        // Read and write together: the write wins, issued right after DONE.
        run_access(1'b1, 1'b1, 1'b0, 32'h0000_0040,
                   128'h0_12345678, 128'h0, -1, 0, -1, 1'b0);
        check_val("both_nwr",   n_wr, 1);
        check_val("both_nrd",   n_rd, 0);
        check_val("both_a0",    {96'h0, acc_addr[0]}, 128'h40);
        check_val("both_d0",    {96'h0, acc_data[0]}, 128'h12345678);
        check_val("both_stall", stall_cnt, 2);
        check_val("both_done_rv", {127'h0, done_rv}, 128'h0);
        check_val("both_rdata_hold", rdata, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);

        // Request held through DONE is not re-accepted there; it becomes a
        // fresh access from IDLE on the following cycle.
        run_access(1'b1, 1'b0, 1'b0, 32'h0000_0010, 128'h0,
                   128'h0_0BADF00D, -1, 0, -1, 1'b1);
        check_val("held_idle_busy",  {127'h0, busy}, 128'h0);
        check_val("held_idle_stall", {127'h0, stall}, 128'h1);
        check_val("held_idle_read",  {127'h0, avm_read}, 128'h0);
        run_access(1'b1, 1'b0, 1'b0, 32'h0000_0010, 128'h0,
                   128'h0_0BADF00D, -1, 0, -1, 1'b0);
        check_val("held_second_stall", stall_cnt, 3);
        check_val("held_second_rdata", rdata, 128'h0_0BADF00D);

        // Reset during RD_WAIT of beat 2 of a vector load.
        run_access(1'b1, 1'b0, 1'b1, 32'h0000_0300, 128'h0,
                   128'h99999999_88888888_77777777_66666666, -1, 0, 2, 1'b0);
        check_val("abort_hit",   {127'h0, aborted}, 128'h1);
        check_val("abort_busy",  {127'h0, busy}, 128'h0);
        check_val("abort_read",  {127'h0, avm_read}, 128'h0);
        check_val("abort_stall", {127'h0, stall}, 128'h0);
        check_val("abort_rdata", rdata, 128'h0);
        check_val("abort_rv",    {127'h0, rdata_valid}, 128'h0);
        rst = 1'b0;
        avm_readdatavalid = 1'b1; avm_readdata = 32'h5555_5555;
        @(posedge clk);
        #1;
        avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
        check_val("late_rdv_rdata", rdata, 128'h0);
        check_val("late_rdv_busy",  {127'h0, busy}, 128'h0);
        run_access(1'b1, 1'b0, 1'b0, 32'h0000_0500, 128'h0,
                   128'h0_CAFEF00D, -1, 0, -1, 1'b0);
        check_val("post_rst_a0",    {96'h0, acc_addr[0]}, 128'h500);
        check_val("post_rst_stall", stall_cnt, 3);
        check_val("post_rst_rdata", rdata, 128'h0_CAFEF00D);
        check_val("post_rst_rv",    {127'h0, done_rv}, 128'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
